alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Consumer end of the ALU operation code: accepts ALUopr/SUBorSRA from the ALU operation signal generator plus two operands.
- Executes the operation and returns a registered result.
- When BranchEn is set, also evaluates the branch condition selected by funct3.
- Sits in the execute stage between decode/operand fetch and writeback/PC-select.
- Valid/ready handshakes on both sides; shifts are iterative (multi-cycle), all other operations take one cycle.

Parameters:
- WIDTH, 32, operand/result width; must be a power of two, minimum 8.
- SHW, 5, shift-amount width = log2(WIDTH).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request present
- in_ready  out  1  unit can accept a request
- ALUopr  in  3  000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND
- SUBorSRA  in  1  selects SUB for 000, SRA for 101; ignored otherwise
- BranchEn  in  1  request is a conditional branch
- funct3  in  3  branch condition: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
- opA  in  WIDTH  operand A / shift source
- opB  in  WIDTH  operand B; shift amount = opB[SHW-1:0]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  registered result
- BranchTaken  out  1  branch condition true; 0 when BranchEn was 0
- zero  out  1  result == 0

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0, result=0, BranchTaken=0, zero=0, in_ready=1. Reset mid-shift aborts the operation and drops it; nothing is emitted after release.
- in_ready=1 only in IDLE; accept occurs when in_valid && in_ready at a rising edge. All inputs are captured at accept; later input changes are ignored.
- FSM states: IDLE, SHIFT, DONE.
- IDLE → DONE: accept of any non-shift op, or a shift with shamt==0. Result is computed and registered on the accept edge; out_valid=1 next cycle (latency 1).
- IDLE → SHIFT: accept of a shift (001/101) with shamt!=0. Each cycle in SHIFT, the working register shifts by one bit and the count decrements. Leaves SHIFT when count reaches 0, entering DONE with the result registered; out_valid rises exactly 1+shamt cycles after accept.
- DONE: out_valid=1; result/BranchTaken/zero held stable until out_ready. On out_valid && out_ready → IDLE. in_ready is low in DONE, so throughput is at most one op per 2 cycles.
- Arithmetic: ADD/SUB are modulo 2^WIDTH with carry discarded. SLT is a signed compare and SLTU unsigned, both giving result = {WIDTH-1 zeros, lt}. SRA replicates opA[WIDTH-1]; SRL and SLL fill with 0. Shift amount uses the low SHW bits only.
- Branch: when BranchEn=1 the result is the ALU result for the supplied ALUopr.
  - BEQ: taken = zero.
  - BNE: taken = !zero.
  - BLT/BLTU: taken = result[0].
  - BGE/BGEU: taken = !result[0].
  - funct3 010/011 with BranchEn=1: BranchTaken=0.
- zero is computed from the final registered result for every operation.
- Simultaneous events: in DONE, out_ready together with in_valid completes the output only; the new request is not accepted that cycle.

Optional Feature:
- Macro: ALU_EXEC_FAST_SHIFT_EN.
- Defined: shifts use a combinational barrel shifter; SHIFT state is never entered and all operations have latency 1.
- Undefined: iterative 1-bit/cycle shifter as described above.
- Handshake, reset and branch behaviour are identical in both builds.

Test Plan:
- Reset: assert rst_n=0 mid-SHIFT (opA=0x1, opB=20, ALUopr=001) → out_valid=0, in_ready=1 immediately; release reset → no result emitted.
- ADD/SUB: opA=5, opB=7, ALUopr=000, SUBorSRA=1 → result=0xFFFFFFFE, zero=0, out_valid one cycle after accept. Repeat with SUBorSRA=0 → result=12.
- SRA vs SRL: opA=0x80000000, opB=4, ALUopr=101 → SUBorSRA=1 gives 0xF8000000; SUBorSRA=0 gives 0x08000000. out_valid 5 cycles after accept (1 with ALU_EXEC_FAST_SHIFT_EN). shamt=0 → result=opA, latency 1.
- Branches: BranchEn=1, ALUopr=000, SUBorSRA=1, opA=opB=9, funct3=000 → BranchTaken=1. Same with funct3=001 → 0. ALUopr=010, opA=-1, opB=1, funct3=100 → 1. ALUopr=011, same operands, funct3=110 → 0.
- Backpressure: hold out_ready=0 for 10 cycles after result → result stable, in_ready=0, new in_valid ignored; raise out_ready → one transfer, IDLE next cycle.
- SLTU/logic sweep: opA=0xFFFF0000, opB=0x0000FFFF → XOR=0xFFFFFFFF, OR=0xFFFFFFFF, AND=0 (zero=1), SLTU=0, SLT=1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with optional conditional-branch evaluation.
// Accepts one request per valid/ready handshake. The result, BranchTaken and zero
// are registered and held until the downstream stage accepts them.
// Shifts run iteratively, one bit per cycle. All other operations take one cycle.
// Optional build macro: ALU_EXEC_FAST_SHIFT_EN. When it is defined, a combinational
// barrel shifter replaces the iterative shifter, and every operation has latency 1.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUopr,
  input  logic             SUBorSRA,
  input  logic             BranchEn,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             BranchTaken,
  output logic             zero
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SRL  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Single-cycle ALU. In the iterative build, a shift only reaches this path
  // when its shift amount is zero, so the operand passes through unchanged.
  function automatic logic [WIDTH-1:0] alu_calc(
    input logic [2:0]       opr,
    input logic             alt,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic        [WIDTH-1:0] r;
`ifdef ALU_EXEC_FAST_SHIFT_EN
    logic        [SHW-1:0]   sh;
    sh = b[SHW-1:0];
`endif
    sa = a;
    sb = b;
    r  = '0;
    case (opr)
      OP_ADD:  r = alt ? (a - b) : (a + b);
`ifdef ALU_EXEC_FAST_SHIFT_EN
      OP_SLL:  r = a << sh;
`else
      OP_SLL:  r = a;
`endif
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, (sa < sb)};
      OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_XOR:  r = a ^ b;
`ifdef ALU_EXEC_FAST_SHIFT_EN
      OP_SRL:  r = alt ? (sa >>> sh) : (a >> sh);
`else
      OP_SRL:  r = a;
`endif
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
    endcase
    return r;
  endfunction

  // Branch condition, derived from the final ALU result.
  function automatic logic branch_eval(
    input logic             en,
    input logic [2:0]       f3,
    input logic [WIDTH-1:0] r
  );
    logic t;
    t = 1'b0;
    if (en) begin
      case (f3)
        BR_BEQ:          t = (r == '0);
        BR_BNE:          t = (r != '0);
        BR_BLT, BR_BLTU: t = r[0];
        BR_BGE, BR_BGEU: t = ~r[0];
        default:         t = 1'b0;
      endcase
    end
    return t;
  endfunction

  logic [WIDTH-1:0] alu_res;
  logic             go_shift;
  logic             fin_load;
  logic [WIDTH-1:0] fin_res;
  logic             fin_en;
  logic [2:0]       fin_f3;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign alu_res   = alu_calc(ALUopr, SUBorSRA, opA, opB);

`ifdef ALU_EXEC_FAST_SHIFT_EN
  assign go_shift = 1'b0;
`else
  // One-bit shift step. A left shift fills with zero. A right shift fills
  // with the sign bit only when it is arithmetic.
  function automatic logic [WIDTH-1:0] shift_one(
    input logic [WIDTH-1:0] w,
    input logic             left,
    input logic             arith
  );
    logic [WIDTH-1:0] r;
    if (left) r = {w[WIDTH-2:0], 1'b0};
    else      r = {arith & w[WIDTH-1], w[WIDTH-1:1]};
    return r;
  endfunction

  logic [WIDTH-1:0] shift_work_p1;
  logic [WIDTH-1:0] shift_next;
  logic [SHW-1:0]   shift_cnt_p1;
  logic             shift_left_p1;
  logic             shift_arith_p1;
  logic             br_en_p1;
  logic [2:0]       br_f3_p1;
  logic             is_shift;
  logic             shift_last;

  assign is_shift   = (ALUopr == OP_SLL) || (ALUopr == OP_SRL);
  assign go_shift   = is_shift && (opB[SHW-1:0] != '0);
  assign shift_next = shift_one(shift_work_p1, shift_left_p1, shift_arith_p1);
  assign shift_last = (shift_cnt_p1 == SHW'(1));
`endif

  // Select what gets written into the output registers, and when.
  always_comb begin
    fin_load = 1'b0;
    fin_res  = alu_res;
    fin_en   = BranchEn;
    fin_f3   = funct3;
    if (state_q == IDLE) begin
      fin_load = in_valid && !go_shift;
    end
`ifndef ALU_EXEC_FAST_SHIFT_EN
    else if ((state_q == SHIFT) && shift_last) begin
      fin_load = 1'b1;
      fin_res  = shift_next;
      fin_en   = br_en_p1;
      fin_f3   = br_f3_p1;
    end
`endif
  end

  // Next-state logic. In DONE, a new request waits until the output has left.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) state_d = go_shift ? SHIFT : DONE;
      end
      SHIFT: begin
`ifdef ALU_EXEC_FAST_SHIFT_EN
        state_d = DONE;
`else
        if (shift_last) state_d = DONE;
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Output registers. They change only when an operation completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result      <= '0;
      BranchTaken <= 1'b0;
      zero        <= 1'b0;
    end else if (fin_load) begin
      result      <= fin_res;
      BranchTaken <= branch_eval(fin_en, fin_f3, fin_res);
      zero        <= (fin_res == '0);
    end
  end

`ifndef ALU_EXEC_FAST_SHIFT_EN
  // Shift counter. It is loaded with the shift amount on accept and counts down once per SHIFT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_cnt_p1 <= '0;
    end else if ((state_q == IDLE) && in_valid && go_shift) begin
      shift_cnt_p1 <= opB[SHW-1:0];
    end else if (state_q == SHIFT) begin
      shift_cnt_p1 <= shift_cnt_p1 - SHW'(1);
    end
  end

  // Operand capture on accept, then one-bit shift steps. Datapath only, so no reset.
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && in_valid) begin
      shift_work_p1  <= opA;
      shift_left_p1  <= (ALUopr == OP_SLL);
      shift_arith_p1 <= SUBorSRA;
      br_en_p1       <= BranchEn;
      br_f3_p1       <= funct3;
    end else if (state_q == SHIFT) begin
      shift_work_p1  <= shift_next;
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit. It compares the DUT against an arithmetic
// reference model and a queue of expected outputs. The stimulus is random,
// plus a set of directed cases with hand-computed values.
module tb_alu_exec_unit;

`ifdef ALU_EXEC_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ALUopr;
  logic        SUBorSRA;
  logic        BranchEn;
  logic [2:0]  funct3;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        BranchTaken;
  logic        zero;

  alu_exec_unit #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUopr(ALUopr), .SUBorSRA(SUBorSRA), .BranchEn(BranchEn), .funct3(funct3),
    .opA(opA), .opB(opB), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .BranchTaken(BranchTaken), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        tk;
    logic        zr;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   tests   = 0;
  int   fails   = 0;
  int   cyc     = 0;
  int   bp_mode = 2;   // 0: random out_ready, 1: hold low, 2: always high
  bit   seen    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain arithmetic on the whole operands.
  function automatic logic [31:0] m_alu(input logic [2:0] opr, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (opr)
      3'd0: return alt ? (a - b) : (a + b);
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        if (alt) return $unsigned($signed(a) >>> sh);
        return a >> sh;
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic m_taken(input logic be, input logic [2:0] f3, input logic [31:0] r);
    if (!be) return 1'b0;
    case (f3)
      3'd0:       return (r == 32'd0);
      3'd1:       return (r != 32'd0);
      3'd4, 3'd6: return r[0];
      3'd5, 3'd7: return !r[0];
      default:    return 1'b0;
    endcase
  endfunction

  function automatic int m_lat(input logic [2:0] opr, input logic [31:0] b);
    if (!FAST && ((opr == 3'd1) || (opr == 3'd5))) return 1 + int'(b[4:0]);
    return 1;
  endfunction

  // Compare process. On every cycle with a valid output it checks the DUT
  // against the head of the expected queue, and it also drives out_ready.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen      = 1'b0;
      out_ready = 1'b0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            chk("latency", 32'(cyc - q[0].acc + 1), 32'(q[0].lat));
          end
          chk("result", result, q[0].res);
          chk("branch_taken", 32'(BranchTaken), 32'(q[0].tk));
          chk("zero", 32'(zero), 32'(q[0].zr));
          chk("in_ready_done", 32'(in_ready), 32'd0);
        end
      end else if ((q.size() > 0) && (cyc >= q[0].acc)) begin
        if (cyc - q[0].acc > 100) begin
          chk("out_valid_timeout", 32'(out_valid), 32'd1);
          void'(q.pop_front());
          seen = 1'b0;
        end else begin
          chk("in_ready_shift", 32'(in_ready), 32'd0);
        end
      end
      case (bp_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
      if (out_valid && out_ready && (q.size() > 0)) begin
        void'(q.pop_front());
        seen = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random don't-care inputs. A request is raised only while the DUT cannot accept it.
  task automatic junk();
    in_valid = in_ready ? 1'b0 : 1'($urandom_range(0, 1));
    ALUopr   = 3'($urandom);
    SUBorSRA = 1'($urandom);
    BranchEn = 1'($urandom);
    funct3   = 3'($urandom);
    opA      = $urandom;
    opB      = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      junk();
      tick();
    end
  endtask

  task automatic send_op(input logic [2:0] opr, input logic alt, input logic be,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] r;
    int          waited;
    waited = 0;
    while (!in_ready && (waited < 200)) begin
      junk();
      tick();
      waited++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    ALUopr   = opr;
    SUBorSRA = alt;
    BranchEn = be;
    funct3   = f3;
    opA      = a;
    opB      = b;
    in_valid = 1'b1;
    r        = m_alu(opr, alt, a, b);
    e.res    = r;
    e.tk     = m_taken(be, f3, r);
    e.zr     = (r == 32'd0);
    e.lat    = m_lat(opr, b);
    e.acc    = cyc + 1;
    q.push_back(e);
    tick();
    junk();
  endtask

  // Check the model against hand-computed literals, then send the same operation to the DUT.
  task automatic pin(input string name, input logic [2:0] opr, input logic alt, input logic be,
                     input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_res, input logic exp_tk, input int exp_lat);
    logic [31:0] r;
    r = m_alu(opr, alt, a, b);
    chk({name, "_model_res"}, r, exp_res);
    chk({name, "_model_taken"}, 32'(m_taken(be, f3, r)), 32'(exp_tk));
    chk({name, "_model_lat"}, 32'(m_lat(opr, b)), 32'(exp_lat));
    send_op(opr, alt, be, f3, a, b);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() > 0) && (n < 400)) begin
      junk();
      tick();
      n++;
    end
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got still running, expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [2:0]  r_opr;
    logic [2:0]  r_f3;
    logic        r_alt;
    logic        r_be;
    logic [31:0] r_a;
    logic [31:0] r_b;

    rst_n = 1'b0; in_valid = 1'b0; ALUopr = 3'd0; SUBorSRA = 1'b0; BranchEn = 1'b0;
    funct3 = 3'd0; opA = 32'd0; opB = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_result", result, 32'd0);
    chk("reset_taken", 32'(BranchTaken), 32'd0);
    chk("reset_zero", 32'(zero), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed operations with hand-computed expectations.
    bp_mode = 2;
    pin("sub",      3'd0, 1'b1, 1'b0, 3'd0, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
    pin("add",      3'd0, 1'b0, 1'b0, 3'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1);
    pin("sub_zero", 3'd0, 1'b1, 1'b0, 3'd0, 32'd9, 32'd9, 32'd0, 1'b0, 1);
    pin("sra",      3'd5, 1'b1, 1'b0, 3'd0, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, FAST ? 1 : 5);
    pin("srl",      3'd5, 1'b0, 1'b0, 3'd0, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, FAST ? 1 : 5);
    pin("sra_sh0",  3'd5, 1'b1, 1'b0, 3'd0, 32'h8000_0000, 32'd0, 32'h8000_0000, 1'b0, 1);
    pin("sll_lowb", 3'd1, 1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h20, 32'h0000_1234, 1'b0, 1);
    pin("sll_max",  3'd1, 1'b0, 1'b0, 3'd0, 32'd1, 32'd31, 32'h8000_0000, 1'b0, FAST ? 1 : 32);
    pin("beq",      3'd0, 1'b1, 1'b1, 3'd0, 32'd9, 32'd9, 32'd0, 1'b1, 1);
    pin("bne",      3'd0, 1'b1, 1'b1, 3'd1, 32'd9, 32'd9, 32'd0, 1'b0, 1);
    pin("blt",      3'd2, 1'b0, 1'b1, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1, 1);
    pin("bge",      3'd2, 1'b0, 1'b1, 3'd5, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
    pin("bltu",     3'd3, 1'b0, 1'b1, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
    pin("br_f3_010",3'd0, 1'b0, 1'b1, 3'd2, 32'd3, 32'd3, 32'd6, 1'b0, 1);
    pin("xor",      3'd4, 1'b0, 1'b0, 3'd0, 32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFF_FFFF, 1'b0, 1);
    pin("or",       3'd6, 1'b0, 1'b0, 3'd0, 32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFF_FFFF, 1'b0, 1);
    pin("and",      3'd7, 1'b0, 1'b0, 3'd0, 32'hFFFF_0000, 32'h0000_FFFF, 32'd0, 1'b0, 1);
    pin("sltu",     3'd3, 1'b0, 1'b0, 3'd0, 32'hFFFF_0000, 32'h0000_FFFF, 32'd0, 1'b0, 1);
    pin("slt",      3'd2, 1'b0, 1'b0, 3'd0, 32'hFFFF_0000, 32'h0000_FFFF, 32'd1, 1'b0, 1);
    drain();

    // Backpressure: the held output stays stable, and new requests are ignored.
    bp_mode = 1;
    send_op(3'd0, 1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0000_1111);
    chk("bp_valid_first", 32'(out_valid), 32'd1);
    repeat (10) begin
      in_valid = 1'b1; ALUopr = 3'($urandom); opA = $urandom; opB = $urandom;
      tick();
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_valid_held", 32'(out_valid), 32'd1);
      chk("bp_result_held", result, 32'h0000_2345);
    end
    bp_mode  = 2;
    in_valid = 1'b1;
    tick();
    chk("bp_transfer_done", 32'(out_valid), 32'd0);
    chk("bp_idle_after", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_no_accept_on_done", 32'(in_ready), 32'd1);

    // Randomized operations with random backpressure.
    bp_mode = 0;
    for (int i = 0; i < 400; i++) begin
      r_opr = 3'($urandom);
      r_alt = 1'($urandom);
      r_be  = ($urandom_range(0, 2) == 0);
      r_f3  = 3'($urandom);
      case ($urandom_range(0, 5))
        0:       r_a = 32'd0;
        1:       r_a = 32'hFFFF_FFFF;
        2:       r_a = 32'h8000_0000;
        3:       r_a = 32'h7FFF_FFFF;
        default: r_a = $urandom;
      endcase
      r_b = ($urandom_range(0, 3) == 0) ? r_a : $urandom;
      if ($urandom_range(0, 5) == 0) r_b[4:0] = 5'd0;
      send_op(r_opr, r_alt, r_be, r_f3, r_a, r_b);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();

    // Reset in the middle of a long shift drops the operation.
    bp_mode = 1;
    send_op(3'd1, 1'b0, 1'b0, 3'd0, 32'd1, 32'd20);
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_result", result, 32'd0);
    chk("rst_mid_zero", 32'(zero), 32'd0);
    chk("rst_mid_taken", 32'(BranchTaken), 32'd0);
    q.delete();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n   = 1'b1;
    bp_mode = 0;
    repeat (30) begin
      tick();
      chk("post_reset_quiet", 32'(out_valid), 32'd0);
    end
    pin("after_reset", 3'd0, 1'b0, 1'b0, 3'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
